// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit_pkg
//  Purpose  : Shared constants and types for the RV64M iterative divider:
//             pipeline-stage indices, datapath width, iteration counter
//             width, FSM state encoding and the op-select encoding.
//  Revision : 1.0  initial release
// ============================================================================
package div_unit_pkg;

    // Pipeline-stage / pipeline-register indices used by the hazard logic
    localparam int STG_IF     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;

    localparam int XLEN   = 64;
    localparam int WORD_W = 32;
    localparam int CNT_W  = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Op select, packed as {is_rem, is_unsigned, is_word}
    typedef struct packed {
        logic is_rem;
        logic is_unsigned;
        logic is_word;
    } div_op_t;

    localparam div_op_t OP_DIV   = 3'b000;
    localparam div_op_t OP_DIVW  = 3'b001;
    localparam div_op_t OP_DIVU  = 3'b010;
    localparam div_op_t OP_DIVUW = 3'b011;
    localparam div_op_t OP_REM   = 3'b100;
    localparam div_op_t OP_REMW  = 3'b101;
    localparam div_op_t OP_REMU  = 3'b110;
    localparam div_op_t OP_REMUW = 3'b111;

    // Sign-extend a 32-bit word result to the full datapath width
    function automatic logic [XLEN-1:0] sext_word(input logic [WORD_W-1:0] v);
        return {{(XLEN-WORD_W){v[WORD_W-1]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit_if
//  Purpose  : EX-stage divide request/result bundle.
//  Signals  : valid_i, is_rem_i, is_unsigned_i, is_word_i, a_i, b_i (request)
//             div_stall_o, result_valid_o, result_o                (response)
//  Modports : master = pipeline side, slave = divider side
//  Revision : 1.0  initial release
// ============================================================================
interface div_unit_if;
    import div_unit_pkg::*;

    logic            valid_i;
    logic            is_rem_i;
    logic            is_unsigned_i;
    logic            is_word_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            div_stall_o;
    logic            result_valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, is_rem_i, is_unsigned_i, is_word_i, a_i, b_i,
        input  div_stall_o, result_valid_o, result_o
    );

    modport slave (
        input  valid_i, is_rem_i, is_unsigned_i, is_word_i, a_i, b_i,
        output div_stall_o, result_valid_o, result_o
    );
endinterface
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-division iteration on magnitudes.
//  Ports    : i_rem, i_quo, i_div -> o_rem, o_quo   (all XLEN wide)
//  Revision : 1.0  initial release
// ============================================================================
module div_step
    import div_unit_pkg::*;
(
    input  wire logic [XLEN-1:0] i_rem,
    input  wire logic [XLEN-1:0] i_quo,
    input  wire logic [XLEN-1:0] i_div,
    output logic      [XLEN-1:0] o_rem,
    output logic      [XLEN-1:0] o_quo
);
    // The shifted partial remainder can exceed XLEN bits when the divisor
    // is near 2^XLEN, so the trial subtract is one bit wider.
    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    always_comb begin
        w_rem_sh = {i_rem, i_quo[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, i_div};
        w_ge     = ~w_diff[XLEN];          // no borrow -> rem >= divisor
        o_rem    = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        o_quo    = {i_quo[XLEN-2:0], w_ge};
    end
endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Iterative radix-2 divider for DIV/DIVU/REM/REMU and W forms.
//             Raises div_stall_o while computing; presents a one-cycle
//             result_valid_o pulse. Divide-by-zero and signed overflow
//             resolve combinationally in IDLE with no stall.
//  Ports    : clk, rst (sync, active-high), bus (div_unit_if.slave)
//  Revision : 1.0  initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    div_unit_if.slave   bus
);
    div_state_e       r_state, w_state_next;
    div_op_t          w_op, r_op;
    logic [XLEN-1:0]  w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_a_res, w_min_neg;
    logic             w_a_neg, w_b_neg, w_div_zero, w_overflow, w_special;
    logic [XLEN-1:0]  w_special_res;
    logic [CNT_W-1:0] w_n, r_cnt;
    logic [XLEN-1:0]  r_rem, r_quo, r_div;
    logic             r_a_neg, r_b_neg;
    logic [XLEN-1:0]  w_step_rem, w_step_quo;
    logic [XLEN-1:0]  w_q_fix, w_r_fix, w_fix, w_done_res;
    logic             w_start, w_stall, w_rvalid;
    logic [XLEN-1:0]  w_result;

    // Operand preparation and zero-latency special cases
    always_comb begin
        w_op = '{is_rem: bus.is_rem_i, is_unsigned: bus.is_unsigned_i,
                 is_word: bus.is_word_i};
        if (w_op.is_word) begin
            w_a_ext   = w_op.is_unsigned ? {{(XLEN-WORD_W){1'b0}}, bus.a_i[WORD_W-1:0]}
                                         : sext_word(bus.a_i[WORD_W-1:0]);
            w_b_ext   = w_op.is_unsigned ? {{(XLEN-WORD_W){1'b0}}, bus.b_i[WORD_W-1:0]}
                                         : sext_word(bus.b_i[WORD_W-1:0]);
            w_a_res   = sext_word(bus.a_i[WORD_W-1:0]);
            w_min_neg = {{(XLEN-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}};
            w_n       = CNT_W'(WORD_W);
        end else begin
            w_a_ext   = bus.a_i;
            w_b_ext   = bus.b_i;
            w_a_res   = bus.a_i;
            w_min_neg = {1'b1, {(XLEN-1){1'b0}}};
            w_n       = CNT_W'(XLEN);
        end
        w_a_neg    = ~w_op.is_unsigned & w_a_ext[XLEN-1];
        w_b_neg    = ~w_op.is_unsigned & w_b_ext[XLEN-1];
        w_a_mag    = w_a_neg ? (~w_a_ext + 1'b1) : w_a_ext;
        w_b_mag    = w_b_neg ? (~w_b_ext + 1'b1) : w_b_ext;
        w_div_zero = (w_b_ext == '0);
        w_overflow = ~w_op.is_unsigned & (w_a_ext == w_min_neg) & (w_b_ext == '1);
        w_special  = w_div_zero | w_overflow;
        if (w_div_zero)
            w_special_res = w_op.is_rem ? w_a_res : '1;
        else
            w_special_res = w_op.is_rem ? '0 : w_a_res;
    end

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // Final sign fix and word sign-extension from the latched op
    always_comb begin
        w_q_fix    = (~r_op.is_unsigned & (r_a_neg ^ r_b_neg)) ? (~r_quo + 1'b1) : r_quo;
        w_r_fix    = (~r_op.is_unsigned & r_a_neg) ? (~r_rem + 1'b1) : r_rem;
        w_fix      = r_op.is_rem ? w_r_fix : w_q_fix;
        w_done_res = r_op.is_word ? sext_word(w_fix[WORD_W-1:0]) : w_fix;
    end

    // FSM next-state and outputs
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_stall      = 1'b0;
        w_rvalid     = 1'b0;
        w_result     = '0;
        case (r_state)
            DIV_IDLE: begin
                if (bus.valid_i) begin
                    if (w_special) begin
                        w_rvalid = 1'b1;
                        w_result = w_special_res;
                    end else begin
                        // Stall in the accept cycle so ID/EX holds the op
                        w_start      = 1'b1;
                        w_stall      = 1'b1;
                        w_state_next = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                w_stall = 1'b1;
                if (r_cnt == CNT_W'(1))
                    w_state_next = DIV_DONE;
            end
            DIV_DONE: begin
                // Always back to IDLE: valid_i here is the same instruction
                w_rvalid     = 1'b1;
                w_result     = w_done_res;
                w_state_next = DIV_IDLE;
            end
            default: w_state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_a_neg <= 1'b0;
            r_b_neg <= 1'b0;
            r_op    <= '0;
        end else if (w_start) begin
            r_rem   <= '0;
            // Word dividends go in the top half so 32 shifts consume them
            r_quo   <= w_op.is_word ? {w_a_mag[WORD_W-1:0], {(XLEN-WORD_W){1'b0}}} : w_a_mag;
            r_div   <= w_b_mag;
            r_cnt   <= w_n;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_op    <= w_op;
        end else if (r_state == DIV_CALC) begin
            r_rem   <= w_step_rem;
            r_quo   <= w_step_quo;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    assign bus.div_stall_o    = w_stall;
    assign bus.result_valid_o = w_rvalid;
    assign bus.result_o       = w_result;
endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 integer divider for the RV64M divide group: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits in the EX stage. It is the producer of the divide stall request that the hazard control block consumes as ex_div_i.
- While it computes, the upstream stages IF, IF/ID and ID/EX are stalled and EX/MEM is flushed.
- The dividing instruction is held stable in ID/EX until the result is presented, then advances.

Parameters:
- XLEN, 64, datapath width; word ops use the low 32 bits.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  ID/EX holds a divide-group instruction this cycle.
- is_rem_i  input  1  1 = remainder result, 0 = quotient result.
- is_unsigned_i  input  1  1 = unsigned (DIVU/REMU/DIVUW/REMUW).
- is_word_i  input  1  1 = *W variant.
- a_i  input  XLEN  dividend (rs1).
- b_i  input  XLEN  divisor (rs2).
- div_stall_o  output  1  stall request; connects to the control block's ex_div_i.
- result_valid_o  output  1  result_o is final this cycle.
- result_o  output  XLEN  quotient or remainder, word results sign-extended.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, div_stall_o=0, result_valid_o=0, result_o=0. Reset mid-operation aborts the operation; the next cycle is IDLE with no stall.
- Operand prep:
  - Word ops: signed ops sign-extend a[31:0] and b[31:0]; unsigned ops zero-extend them.
  - Magnitudes are taken for signed ops.
  - Iteration count N = 32 for word ops, XLEN otherwise.
- Special cases are resolved in IDLE with zero latency: div_stall_o=0, result_valid_o=1, result_o driven combinationally.
  - Divide by zero: quotient = all ones (at the active width); remainder = dividend.
  - Signed overflow (most-negative / -1, at the active width): quotient = dividend; remainder = 0.
- States:
  - IDLE:
    - valid_i=1 and not a special case: latch operands, signs, op and N; counter=N; go to CALC. div_stall_o=1 combinationally in this same cycle, so ID/EX holds.
    - Otherwise: stay in IDLE.
  - CALC:
    - div_stall_o=1.
    - Each cycle performs one restoring step: shift {rem,quo} left 1; if rem >= divisor magnitude, subtract and set quotient bit 0 to 1.
    - Decrement the counter; at counter==1 go to DONE.
    - valid_i and the operand inputs are ignored, since the latched copy is authoritative.
  - DONE:
    - div_stall_o=0 and result_valid_o=1 for exactly one cycle; the pipeline advances this cycle.
    - Sign fix: signed quotient is negated if operand signs differ; signed remainder takes the dividend's sign.
    - Word results are sign-extended from bit 31, including the unsigned W forms.
    - Next state is IDLE unconditionally. valid_i in DONE never restarts the unit, which prevents re-executing the same instruction.
- Latency: stall is asserted for N+1 cycles (the IDLE accept cycle plus N CALC cycles); the result appears in cycle N+2.
  - 64-bit ops: 65 stall cycles.
  - Word ops: 33 stall cycles.
- Back-to-back divides: the second divide reaches ID/EX the cycle after DONE, is seen in IDLE and starts normally. There are no idle bubbles beyond DONE.
- result_o and result_valid_o are don't-care/0 while CALC is active.

Decomposition:
- Shared package/define file:
  - State encodings DIV_IDLE / DIV_CALC / DIV_DONE.
  - The op-select encoding {is_rem, is_unsigned, is_word}.
  - XLEN, defined beside the existing pipeline-stage index constants (IF=0 … MEM/WB=4).
- One natural sub-module: div_step, a combinational single restoring iteration taking rem, quo and divisor and returning the next rem and quo. It is reusable for a future radix-4 variant by instantiating it twice.

Test Plan:
1. DIV a=20, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> div_stall_o high exactly 65 cycles; result_valid_o one cycle; result_o=0xFFFF_FFFF_FFFF_FFFA. REM with the same operands -> 0x2.
2. DIVUW a=0x1234_5678_8000_0000, b=0x0000_0000_0000_0002 -> stall high 33 cycles; result_o=0x0000_0000_4000_0000. DIVUW a=0xFFFF_FFFE, b=1 -> 0xFFFF_FFFF_FFFF_FFFE (sign-extended).
3. REMU a=0x55, b=0 -> no stall; result_valid_o same cycle; result_o=0x55. DIV a=7, b=0 -> 0xFFFF_FFFF_FFFF_FFFF.
4. DIV a=0x8000_0000_0000_0000, b=-1 -> no stall; result_o=0x8000_0000_0000_0000. DIVW a=0x8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000. REMW with the same operands -> 0.
5. Start DIVU 100/7; assert rst in CALC cycle 10 -> next cycle div_stall_o=0, result_valid_o=0, result_o=0. Re-present the same op -> full 65-cycle run; result_o=14.
6. Back-to-back DIVU 100/7 then REMU 100/7, with valid_i held high through DONE -> two separate runs; results 14 then 2; exactly one result_valid_o pulse per instruction.
